// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the iterative round blocks.
// Multipliers are built from chained xtime (reduction polynomial 0x11B).
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } imc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mixcolumn_word.sv
// Combinational InvMixColumns transform of one 32-bit column.
// Byte 0 of the column is the MSB byte.
module inv_mixcolumn_word
    import aes_pkg::*;
(
    input  word_t col_in,
    output word_t col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign col_out[31:24] = gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3);
    assign col_out[23:16] = gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3);
    assign col_out[15:8]  = gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3);
    assign col_out[7:0]   = gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3);

endmodule

// File: rtl/inv_mixcolumn_iter.sv
// Iterative InvMixColumns: one column per clock through a shared column engine,
// result held on a valid/ready output until accepted.
module inv_mixcolumn_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    imc_state_e state, state_next;
    logic [1:0] col, col_next;
    state_t     st, st_next;
    word_t      col_cur, col_new;

    always_comb begin
        case (col)
            2'd0:    col_cur = st[127:96];
            2'd1:    col_cur = st[95:64];
            2'd2:    col_cur = st[63:32];
            default: col_cur = st[31:0];
        endcase
    end

    inv_mixcolumn_word u_word (
        .col_in  (col_cur),
        .col_out (col_new)
    );

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign out_data  = st;

    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        col_next   = col;
        st_next    = st;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    st_next    = in_data;
                    col_next   = 2'd0;
                    state_next = CALC;
                end
            end
            CALC: begin
                case (col)
                    2'd0:    st_next[127:96] = col_new;
                    2'd1:    st_next[95:64]  = col_new;
                    2'd2:    st_next[63:32]  = col_new;
                    default: st_next[31:0]   = col_new;
                endcase
                col_next = col + 2'd1;
                if (col == 2'd3) state_next = DONE;
            end
            DONE: begin
                // Without out_ready the result is held and in_valid is ignored.
                if (out_ready) begin
                    if (in_valid) begin
                        st_next    = in_data;
                        col_next   = 2'd0;
                        state_next = CALC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: st is a plain register, so it is reset along with the FSM; out_data reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= 2'd0;
            st    <= '0;
        end else begin
            // NOTE: non-blocking updates so all state changes land together at the edge.
            state <= state_next;
            col   <= col_next;
            st    <= st_next;
        end
    end

endmodule

// File: tb/tb_inv_mixcolumn_iter.sv
// Self-checking bench for inv_mixcolumn_iter against a matrix-level GF(2^8) model.
module tb_inv_mixcolumn_iter;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    inv_mixcolumn_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic shift-and-add GF(2^8) multiply, poly 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Circulant matrix column transform: b_r = XOR_c base[(c-r) mod 4] * a_c.
    function automatic logic [31:0] col_xform(input logic [31:0] w, input logic [31:0] base_w);
        logic [7:0] a [4];
        logic [7:0] base [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            a[i]    = w[31-8*i -: 8];
            base[i] = base_w[31-8*i -: 8];
        end
        r = '0;
        for (int row = 0; row < 4; row++) begin
            logic [7:0] acc;
            acc = 8'h00;
            for (int c = 0; c < 4; c++) acc ^= gmul(base[(c - row + 4) % 4], a[c]);
            r[31-8*row -: 8] = acc;
        end
        return r;
    endfunction

    function automatic logic [127:0] state_xform(input logic [127:0] s, input logic [31:0] base_w);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) r[127-32*c -: 32] = col_xform(s[127-32*c -: 32], base_w);
        return r;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        return state_xform(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        return state_xform(s, 32'h02030101);
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present s until accepted (bounded), returning 1ns after the accepting edge.
    task automatic send(input logic [127:0] s);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = s;
        #0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("send_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rand_state();
    endtask

    // Called 1ns after an accepting edge; counts cycles until out_valid.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic transform(input string tag, input logic [127:0] s, input logic [127:0] exp);
        int lat;
        send(s);
        wait_valid(lat);
        check({tag, "_latency"}, 128'(lat), 128'd4);
        check({tag, "_data"}, out_data, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [127:0] s, hold, q [$];
        int lat, idx, oidx, last, cyc;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("reset_out_data", out_data, 128'd0);
        check("reset_in_ready", {127'd0, in_ready}, 128'd1);

        // Known vectors
        transform("known", {4{32'h8e4da1bc}}, {4{32'hdb135345}});
        check("known_model", inv_mix({4{32'h8e4da1bc}}), {4{32'hdb135345}});
        transform("mixed", 128'h8e4da1bc_9fdc589d_4d7ebdf8_d5d5d7d6,
                  128'hdb135345_f20a225c_2d26314c_d4d4d4d5);
        transform("fixed_01", {16{8'h01}}, {16{8'h01}});
        transform("fixed_c6", {16{8'hc6}}, {16{8'hc6}});

        // Backpressure
        out_ready = 1'b0;
        s = rand_state();
        send(s);
        wait_valid(lat);
        check("bp_latency", 128'(lat), 128'd4);
        hold = out_data;
        check("bp_data", hold, inv_mix(s));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = rand_state();
            #0;
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
            check("bp_out_valid", {127'd0, out_valid}, 128'd1);
            check("bp_stable", out_data, hold);
            @(posedge clk); #1;
        end
        s = rand_state();
        in_data   = s;
        out_ready = 1'b1;
        #0;
        check("bp_release_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accepted", {127'd0, out_valid}, 128'd0);
        wait_valid(lat);
        check("bp_next_latency", 128'(lat), 128'd4);
        check("bp_next_data", out_data, inv_mix(s));
        @(posedge clk); #1;

        // Back-to-back stream of 20 random states
        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(rand_state());
        idx = 0; oidx = 0; last = 0; cyc = 0;
        while (oidx < 20 && cyc < 300) begin
            in_valid = (idx < 20);
            in_data  = (idx < 20) ? q[idx] : '0;
            #0;
            if (out_valid) begin
                check("stream_data", out_data, inv_mix(q[oidx]));
                check("stream_roundtrip", fwd_mix(out_data), q[oidx]);
                if (oidx > 0) check("stream_gap", 128'(cyc - last), 128'd5);
                last = cyc;
                oidx++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_count", 128'(oidx), 128'd20);
        repeat (2) @(posedge clk); #1;

        // Reset in the CALC cycle with col==2
        send(rand_state());
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_out_valid", {127'd0, out_valid}, 128'd0);
        check("midreset_out_data", out_data, 128'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("midreset_in_ready", {127'd0, in_ready}, 128'd1);
        s = rand_state();
        transform("post_reset", s, inv_mix(s));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
